sdram_rd_capture: RTL
=====================

Name: sdram_rd_capture

Overview:
- Read-side capture for the SDRAM controller, at the input end of the SDRAM pin interface that the DDR clock-output pad drives.
- Registers DQ input pins and tracks each issued READ command through the CAS-latency window.
- Emits tagged, beat-framed read data (valid/last) to the controller's read-return path.
- Sits between the DQ input pads and the controller request/return logic, in the SDRAM clock domain.

Parameters:
DQ_WIDTH, 16, width of SDRAM DQ bus and rd_data.
CAS_LATENCY, 2, SDRAM CAS latency in clk cycles (legal 1..3).
IN_REGS, 1, DQ input register stages before rd_data (legal 1..3); first stage is the pad capture register.
BURST_LEN, 4, beats per READ burst (legal 1, 2, 4, 8).
TAG_WIDTH, 4, width of the request tag carried with each READ.

Ports:
clk  in  1  SDRAM-domain clock; same clock as the controller command path.
rst_n  in  1  asynchronous, active-low reset.
rd_issue  in  1  high for one cycle when a READ command is driven on the SDRAM command pins.
rd_tag_in  in  TAG_WIDTH  tag for the READ, sampled with rd_issue.
flush  in  1  synchronous; discards all pending and in-progress reads.
dq_in  in  DQ_WIDTH  SDRAM DQ input pins.
rd_data  out  DQ_WIDTH  captured read beat.
rd_valid  out  1  rd_data holds a valid beat this cycle.
rd_last  out  1  final beat of a full burst.
rd_beat  out  3  beat index within the burst (0..BURST_LEN-1).
rd_tag  out  TAG_WIDTH  tag of the burst owning the current beat.
rd_trunc  out  1  one-cycle pulse: the previous burst was cut short by a new one.

Behaviour:
- Reset, asynchronous on rst_n low:
  - All outputs go to 0.
  - All schedule-pipeline valid bits, the burst counter and the DQ pipeline clear.
  - Any burst in flight at reset is dropped; no partial beats after release.
- Schedule pipeline:
  - Shift register of depth CAS_LATENCY+IN_REGS-1, entries {valid, tag}.
  - rd_issue pushes {1, rd_tag_in}; otherwise pushes {0, x}.
- Timing: rd_issue sampled at edge k gives these beats.
  - Beat j (0..BURST_LEN-1) is the dq_in value sampled at edge k+CAS_LATENCY+j.
  - It appears on rd_data with rd_valid=1 and rd_beat=j after edge k+CAS_LATENCY+IN_REGS-1+j.
  - rd_tag is constant for all beats of a burst.
- Burst state machine, states IDLE and BURST:
  - IDLE -> BURST when the schedule head is valid. Counter loads 0 and the tag latches.
  - In BURST the counter increments each cycle. rd_last=1 when counter=BURST_LEN-1 and the burst is not truncated.
  - BURST -> IDLE after the last beat, unless the head is valid that same cycle. In that case BURST continues, the counter reloads 0, the new tag latches, rd_last is on the old beat and rd_trunc=0 (gapless back-to-back).
- Truncation:
  - Head becomes valid while counter<BURST_LEN-1: the old burst ends without rd_last.
  - The new burst's beat 0 is output that cycle, with rd_trunc=1 for that cycle.
- BURST_LEN=1: every beat has rd_last=1, and rd_beat is always 0.
- rd_data:
  - Updates every cycle from the DQ pipeline, regardless of rd_valid.
  - Consumers qualify it with rd_valid.
- flush:
  - Takes effect at the edge where it is high: clears schedule valids, forces IDLE, rd_valid=0 next cycle.
  - rd_issue in the same cycle as flush is discarded.
- rd_issue while the pipeline is full of issues: legal. Every cycle is a valid push; only truncation semantics apply.
- rd_beat is 3 bits wide; upper bits are 0 when BURST_LEN<8.

Test Plan:
- CL=2, IN_REGS=1, BL=4: rd_issue tag=5 at edge 10; dq_in=A000..A003 at edges 12..15 -> rd_valid after edges 12..15, rd_data A000..A003, rd_beat 0..3, rd_tag=5, rd_last only after edge 15.
- Back-to-back: issues at edges 10 (tag 1) and 14 (tag 2) -> 8 contiguous valid beats, rd_last after edges 15 and 19, rd_trunc never asserted.
- Truncation: issues at edges 10 (tag 1) and 12 (tag 2) -> tag 1 beats 0,1 only, no rd_last; rd_trunc=1 with tag 2 beat 0 after edge 14; tag 2 completes with rd_last after edge 17.
- Reset mid-burst: rst_n low between edges 13 and 14 -> all outputs 0 immediately; no rd_valid afterwards until a new issue.
- flush at edge 11 after issue at edge 10 -> no rd_valid; an issue at edge 12 then returns normally after edges 14..17.
- IN_REGS=3, CL=3, BL=1: issue at edge 20 -> single beat, rd_valid and rd_last after edge 25, data = dq_in at edge 23.

Source files
------------

// File: rtl/sdram_rd_capture.sv
// sdram_rd_capture
// Read-side capture for the SDRAM controller, sitting between the DQ input
// pads and the controller's read-return path in the SDRAM clock domain.
// Every issued READ is tracked through the CAS-latency window in a schedule
// shift register. When it reaches the head, a small burst machine frames the
// beats coming out of the DQ input pipeline with valid/last/beat/tag.
//
// Parameters
//   DQ_WIDTH    : DQ bus / rd_data width
//   CAS_LATENCY : SDRAM CAS latency in clk cycles (1..3)
//   IN_REGS     : DQ register stages before rd_data, pad register included (1..3)
//   BURST_LEN   : beats per READ burst (1, 2, 4, 8)
//   TAG_WIDTH   : request tag width
//
// Ports
//   clk        in   SDRAM-domain clock
//   rst_n      in   asynchronous active-low reset
//   rd_issue   in   one-cycle strobe, READ driven on the command pins
//   rd_tag_in  in   tag for the READ, sampled with rd_issue
//   flush      in   synchronous discard of all pending/in-progress reads
//   dq_in      in   SDRAM DQ input pins
//   rd_data    out  captured beat; updates every cycle, qualify with rd_valid
//   rd_valid   out  rd_data holds a valid beat
//   rd_last    out  final beat of a complete burst
//   rd_beat    out  beat index within the burst
//   rd_tag     out  tag of the burst owning the current beat
//   rd_trunc   out  one-cycle pulse on beat 0 of a burst that cut the previous one short

module sdram_rd_capture #(
  parameter int unsigned DQ_WIDTH    = 16,
  parameter int unsigned CAS_LATENCY = 2,
  parameter int unsigned IN_REGS     = 1,
  parameter int unsigned BURST_LEN   = 4,
  parameter int unsigned TAG_WIDTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rd_issue,
  input  logic [TAG_WIDTH-1:0] rd_tag_in,
  input  logic                 flush,
  input  logic [DQ_WIDTH-1:0]  dq_in,
  output logic [DQ_WIDTH-1:0]  rd_data,
  output logic                 rd_valid,
  output logic                 rd_last,
  output logic [2:0]           rd_beat,
  output logic [TAG_WIDTH-1:0] rd_tag,
  output logic                 rd_trunc
);

  // A READ must surface at the schedule head one cycle before its first beat
  // leaves the DQ pipeline, so the burst machine can register it alongside.
  localparam int unsigned SCHED_DEPTH = CAS_LATENCY + IN_REGS - 1;
  localparam logic [2:0]  LAST_BEAT   = 3'(BURST_LEN - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  typedef struct packed {
    logic                 vld;
    logic [TAG_WIDTH-1:0] tag;
  } sched_t;

  sched_t               sched_q [SCHED_DEPTH];
  sched_t               sched_d [SCHED_DEPTH];
  logic  [DQ_WIDTH-1:0] dq_q    [IN_REGS];
  logic  [DQ_WIDTH-1:0] dq_d    [IN_REGS];

  state_e               state_q, state_d;
  logic  [2:0]          cnt_q, cnt_d;
  logic  [TAG_WIDTH-1:0] tag_q, tag_d;
  logic                 valid_q, valid_d;
  logic                 last_q, last_d;
  logic                 trunc_q, trunc_d;

  sched_t               head;

  assign head = sched_q[SCHED_DEPTH-1];

  // Schedule shift register and DQ input pipeline.
  always_comb begin
    sched_d[0].vld = rd_issue & ~flush;
    sched_d[0].tag = rd_issue ? rd_tag_in : '0;
    for (int unsigned i = 1; i < SCHED_DEPTH; i++) begin
      sched_d[i] = sched_q[i-1];
    end
    // flush kills everything already scheduled
    if (flush) begin
      for (int unsigned i = 0; i < SCHED_DEPTH; i++) begin
        sched_d[i].vld = 1'b0;
      end
    end

    dq_d[0] = dq_in;
    for (int unsigned i = 1; i < IN_REGS; i++) begin
      dq_d[i] = dq_q[i-1];
    end
  end

  // Burst framing: next state and registered output values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tag_d   = tag_q;
    valid_d = 1'b0;
    last_d  = 1'b0;
    trunc_d = 1'b0;

    if (flush) begin
      state_d = ST_IDLE;
    end else if (head.vld) begin
      // A new burst always wins; if the current one has not yet shown its
      // last beat it is abandoned and the new beat 0 is flagged.
      state_d = ST_BURST;
      cnt_d   = 3'd0;
      tag_d   = head.tag;
      valid_d = 1'b1;
      last_d  = (LAST_BEAT == 3'd0);
      trunc_d = (state_q == ST_BURST) && (cnt_q < LAST_BEAT);
    end else if ((state_q == ST_BURST) && (cnt_q < LAST_BEAT)) begin
      cnt_d   = 3'(cnt_q + 3'd1);
      valid_d = 1'b1;
      last_d  = (3'(cnt_q + 3'd1) == LAST_BEAT);
    end else begin
      state_d = ST_IDLE;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SCHED_DEPTH; i++) begin
        sched_q[i] <= '0;
      end
      for (int unsigned i = 0; i < IN_REGS; i++) begin
        dq_q[i] <= '0;
      end
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      tag_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      trunc_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < SCHED_DEPTH; i++) begin
        sched_q[i] <= sched_d[i];
      end
      for (int unsigned i = 0; i < IN_REGS; i++) begin
        dq_q[i] <= dq_d[i];
      end
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      trunc_q <= trunc_d;
    end
  end

  assign rd_data  = dq_q[IN_REGS-1];
  assign rd_valid = valid_q;
  assign rd_last  = last_q;
  assign rd_beat  = cnt_q;
  assign rd_tag   = tag_q;
  assign rd_trunc = trunc_q;

endmodule
